// File: rtl/imloader_if.sv
// imloader_if: byte-stream handshake from upstream plus the instruction-memory write port
interface imloader_if #(
  parameter int AW = 8,
  parameter int IW = 24
);
  logic          invalid;
  logic [7:0]    indata;
  logic          inready;
  logic          imwe;
  logic [AW-1:0] imaddr;
  logic [IW-1:0] imdata;
  modport master (output invalid, indata, input inready, imwe, imaddr, imdata);
  modport slave  (input invalid, indata, output inready, imwe, imaddr, imdata);
endinterface

// File: rtl/imloader.sv
// imloader: assembles a checksummed byte stream into 24-bit instructions, writes them to
// instruction memory and releases the core only after a clean load.
module imloader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int IW    = 24
) (
  input  logic       clk,
  input  logic       rstn,
  imloader_if.slave  bus,
  output logic       cpuhold,
  output logic       done,
  output logic       error
);
  typedef enum logic [2:0] {IDLE, B0, B1, B2, WRITE, CHECK, RUN, ERR} state_t;
  state_t        state, nxt;
  logic [AW-1:0] index, last;
  logic [7:0]    sum;
  logic [IW-1:0] word;
  logic          take;
  assign take       = bus.invalid && bus.inready;
  assign bus.imaddr = index;
  assign bus.imdata = word;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  // Handshake and status outputs depend only on the registered state.
  always_comb begin
    nxt         = state;
    bus.inready = 1'b0;
    bus.imwe    = 1'b0;
    cpuhold     = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    case (state)
      IDLE: begin
        bus.inready = 1'b1;
        nxt = take ? B0 : IDLE;
      end
      B0: begin
        bus.inready = 1'b1;
        nxt = take ? B1 : B0;
      end
      B1: begin
        bus.inready = 1'b1;
        nxt = take ? B2 : B1;
      end
      B2: begin
        bus.inready = 1'b1;
        nxt = take ? WRITE : B2;
      end
      WRITE: begin
        bus.imwe = 1'b1;
        nxt = (index == last) ? CHECK : B0;
      end
      CHECK: begin
        bus.inready = 1'b1;
        nxt = !take ? CHECK : (bus.indata == sum) ? RUN : ERR;
      end
      RUN: begin
        cpuhold = 1'b0;
        done    = 1'b1;
      end
      default: error = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      index <= '0;
      last  <= AW'(DEPTH - 1);
      sum   <= '0;
      word  <= '0;
    end else begin
      if (state == IDLE) begin
        index <= '0;
        sum   <= take ? bus.indata : 8'd0;
        if (take) last <= AW'(bus.indata - 8'd1);
      end
      if (take && (state == B0 || state == B1 || state == B2)) sum <= sum + bus.indata;
      if (take && state == B0) word[23:16] <= bus.indata;
      if (take && state == B1) word[15:8]  <= bus.indata;
      if (take && state == B2) word[7:0]   <= bus.indata;
      if (state == WRITE && index != last) index <= index + 1'b1;
    end
endmodule

// File: tb/tb_imloader.sv
// tb_imloader: randomized and directed loads checked against a stream-level reference model.
module tb_imloader;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cpuhold, done, error;
  imloader_if bi ();
  imloader dut (.clk(clk), .rstn(rstn), .bus(bi), .cpuhold(cpuhold), .done(done), .error(error));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic [23:0] prog[$];
  logic [7:0]  stream[$];
  logic [7:0]  exp_a[$];
  logic [23:0] exp_d[$];
  logic        exp_ok;
  logic [7:0]  wa[$];
  logic [23:0] wd[$];
  always @(negedge clk)
    if (rstn && bi.imwe) begin
      wa.push_back(bi.imaddr);
      wd.push_back(bi.imdata);
    end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Reference model: stream bytes, expected writes and checksum outcome from the program.
  task automatic make(bit corrupt);
    int s;
    logic [7:0] b;
    stream.delete(); exp_a.delete(); exp_d.delete();
    stream.push_back(8'(prog.size()));
    s = int'(stream[0]);
    foreach (prog[i]) begin
      for (int k = 2; k >= 0; k--) begin
        b = 8'(prog[i] >> (8 * k));
        stream.push_back(b);
        s += int'(b);
      end
      exp_a.push_back(8'(i));
      exp_d.push_back(prog[i]);
    end
    stream.push_back(8'(s - (corrupt ? 1 : 0)));
    exp_ok = !corrupt;
  endtask
  task automatic drive(int gap, int limit, int upto, output int cyc);
    int i = 0;
    bit acc;
    cyc = 0;
    while (i < upto && cyc < limit) begin
      @(negedge clk);
      if (gap > 0 && $urandom_range(99) < gap) begin
        bi.invalid = 1'b0;
        bi.indata  = 8'($urandom);
      end else begin
        bi.invalid = 1'b1;
        bi.indata  = stream[i];
      end
      acc = bi.invalid && bi.inready;
      @(posedge clk);
      cyc++;
      if (acc) i++;
    end
    @(negedge clk);
    bi.invalid = 1'b0;
    chk("bytes_taken", i, upto);
  endtask
  task automatic check_writes(string tag);
    chk({tag, "_nwr"}, wa.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], exp_a[i]);
      chk({tag, "_data"}, wd[i], exp_d[i]);
    end
  endtask
  task automatic check_end(string tag);
    chk({tag, "_done"}, done, exp_ok);
    chk({tag, "_error"}, error, !exp_ok);
    chk({tag, "_cpuhold"}, cpuhold, !exp_ok);
    chk({tag, "_inready"}, bi.inready, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    bi.invalid = 1'b0;
    #1;
    chk("rst_inready", bi.inready, 1);
    chk("rst_imwe", bi.imwe, 0);
    chk("rst_cpuhold", cpuhold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rstn = 1'b1;
    wa.delete(); wd.delete();
  endtask
  initial begin
    int cyc;
    logic [7:0] v;
    bi.invalid = 1'b0;
    bi.indata  = 8'h00;
    #12;
    chk("init_inready", bi.inready, 1);
    chk("init_imwe", bi.imwe, 0);
    chk("init_imaddr", bi.imaddr, 0);
    chk("init_imdata", bi.imdata, 0);
    chk("init_cpuhold", cpuhold, 1);
    chk("init_done", done, 0);
    chk("init_error", error, 0);
    @(negedge clk);
    rstn = 1'b1;
    prog = '{24'h010203, 24'hAABBCC};
    make(0);
    drive(0, 100, stream.size(), cyc);
    chk("two_cycles", cyc, 10);
    check_writes("two");
    check_end("two");
    do_reset();
    make(1);
    drive(0, 100, stream.size(), cyc);
    check_writes("badck");
    check_end("badck");
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      bi.invalid = 1'b1;
      bi.indata  = 8'($urandom);
      chk("badck_after_inready", bi.inready, 0);
    end
    @(negedge clk);
    bi.invalid = 1'b0;
    chk("badck_after_nwr", wa.size(), 2);
    chk("badck_after_error", error, 1);
    do_reset();
    prog = '{24'h010203, 24'h050607};
    make(0);
    drive(0, 100, stream.size(), cyc);
    chk("write_stall_cycles", cyc, 10);
    check_writes("write_stall");
    check_end("write_stall");
    do_reset();
    drive(40, 400, stream.size(), cyc);
    check_writes("gaps");
    check_end("gaps");
    for (int t = 0; t < 4; t++) begin
      do_reset();
      prog.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) prog.push_back(24'($urandom));
      make(t == 3);
      drive(30, 500, stream.size(), cyc);
      check_writes("rand");
      check_end("rand");
    end
    do_reset();
    prog.delete();
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      prog.push_back({v, ~v, v});
    end
    make(0);
    drive(0, 3000, stream.size(), cyc);
    chk("full_cycles", cyc, 1026);
    check_writes("full");
    check_end("full");
    repeat (5) @(negedge clk);
    chk("full_no_extra_write", wa.size(), 256);
    do_reset();
    prog = '{24'h010203, 24'hAABBCC};
    make(0);
    drive(0, 100, 4, cyc);
    chk("mid_write_imwe", bi.imwe, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_write_rst_imwe", bi.imwe, 0);
    chk("mid_write_rst_cpuhold", cpuhold, 1);
    chk("mid_write_rst_inready", bi.inready, 1);
    @(negedge clk);
    rstn = 1'b1;
    wa.delete(); wd.delete();
    drive(0, 100, 6, cyc);
    #2 rstn = 1'b0;
    #1;
    chk("midload_rst_imwe", bi.imwe, 0);
    chk("midload_rst_cpuhold", cpuhold, 1);
    chk("midload_rst_inready", bi.inready, 1);
    @(negedge clk);
    rstn = 1'b1;
    wa.delete(); wd.delete();
    prog = '{24'h112233};
    make(0);
    chk("reload_ck_byte", stream[4], 8'h67);
    drive(0, 100, stream.size(), cyc);
    check_writes("reload");
    check_end("reload");
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bi.invalid = 1'b1;
      bi.indata  = 8'($urandom);
      chk("post_inready", bi.inready, 0);
      chk("post_imwe", bi.imwe, 0);
      chk("post_done", done, 1);
      chk("post_cpuhold", cpuhold, 0);
    end
    @(negedge clk);
    bi.invalid = 1'b0;
    chk("post_nwr", wa.size(), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imloader.md
# imloader

Program loader sitting directly upstream of the instruction memory of the 8-bit single-cycle core. It accepts a byte stream over a valid/ready handshake and assembles 24-bit instructions MSB first. Each instruction is written through the instruction memory's synchronous write port, and the stream is checked against a trailing checksum byte. The core's PC is held in hold until a load completes cleanly; only then is the core released to execute from address 0.

## Interface
- DEPTH, 256: instruction memory words; equals 2^AW.
- AW, 8: address width; matches the 8-bit PC.
- IW, 24: instruction width; fixed at 3 bytes.

- clk  in  1  system clock; all state changes on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- invalid  in  1  upstream byte valid.
- indata  in  8  upstream byte.
- inready  out  1  loader can accept a byte; transfer occurs on an edge where invalid && inready.
- imwe  out  1  instruction memory write enable; one-cycle pulse per instruction.
- imaddr  out  AW  write address.
- imdata  out  IW  write data.
- cpuhold  out  1  1 = core PC held at 0 and regwrite/memwrite suppressed.
- done  out  1  load complete, checksum matched.
- error  out  1  checksum mismatch.

## Operation
- Stream format: count byte N, then 3·N instruction bytes (MSB, mid, LSB per instruction), then checksum byte.
- N = 0 means 256 instructions.
- Checksum rule: the checksum byte must equal the mod-256 sum of the count byte and all instruction bytes.
- Running sum: an 8-bit accumulator, cleared in IDLE. The count byte and every instruction byte are added on acceptance.
- FSM states: IDLE, B0, B1, B2, WRITE, CHECK, RUN, ERR.
- IDLE: accept the count byte. Latch last = N-1 (8-bit wrap, so N=0 gives last=255). Clear index. Go to B0.
- B0/B1/B2: accept one byte each into imdata[23:16], [15:8], [7:0] respectively. B2 goes to WRITE.
- WRITE: inready=0, imwe=1, imaddr=index.
  - If index==last, go to CHECK.
  - Else increment index and go to B0.
- CHECK: accept one byte.
  - If the byte equals the sum, go to RUN.
  - Else go to ERR.
- RUN: cpuhold=0, done=1, inready=0. The state is terminal until reset.
- ERR: error=1, cpuhold=1, inready=0. The state is terminal until reset.
- In every state other than RUN or ERR, the stalled state simply waits while invalid=0. There is no timeout.
- index never exceeds last, so the address never wraps past DEPTH-1.
- Previously written memory words are never erased; a new load overwrites only addresses 0..last.

## Timing
- Reset values (immediate on rstn low, held until the first edge after release):
  - state=IDLE, index=0, sum=0, imdata=0, imaddr=0.
  - imwe=0, inready=1, cpuhold=1, done=0, error=0.
- Reset mid-load: state returns to IDLE asynchronously and the partial instruction is discarded. An imwe pulse in progress is dropped (imwe=0 immediately).
- inready, imwe, done and error are decoded from the registered state. Neither output depends combinationally on invalid or indata.
- Throughput: 4 cycles per instruction minimum (3 accepted bytes + 1 WRITE cycle).
- A byte presented during WRITE is not consumed. Upstream holds it, and it is accepted in the following B0 cycle.
- Latency: LSB accepted at edge k. imwe/imaddr/imdata are valid during cycle k..k+1, and memory captures at edge k+1.
- Final checksum byte accepted at edge c. done (or error) rises and cpuhold falls (or stays 1) after edge c. The core's first fetch from address 0 happens in the cycle after edge c.
- Minimum full load of N instructions: 1 + 4N + 1 cycles with invalid held high.

## Test plan
- **Two-instruction load.**
  - Stimulus: 0x02, 0x01 0x02 0x03, 0xAA 0xBB 0xCC, checksum 0x39, invalid held high.
  - Required: imwe pulses at addr 0 with 0x010203 and at addr 1 with 0xAABBCC. Then done=1, cpuhold=0, inready=0; total 10 cycles.
- **Bad checksum.**
  - Stimulus: same stream with final byte 0x38.
  - Required: both writes still occur, then error=1, done=0, cpuhold=1, inready=0. A following byte is not accepted.
- **Backpressure and gaps.**
  - Stimulus: invalid toggles randomly. Also present 0x05 as the first byte of instruction 2 during WRITE.
  - Required: the byte is not consumed in WRITE and is accepted in the next cycle. Written words are identical to the gap-free run.
- **Count 0 (full memory).**
  - Stimulus: count 0x00, 768 bytes where instruction i = {i, ~i, i}, correct checksum.
  - Required: 256 imwe pulses at addr 0..255 in order, no write after 255, done=1.
- **Reset mid-load.**
  - Stimulus: assert rstn low between bytes 0xBB and 0xCC of the two-instruction stream; release; send 0x01, 0x11 0x22 0x33, 0x67.
  - Required:
    - On reset assertion: imwe=0, cpuhold=1, inready=1 without waiting for a clock.
    - After the reload: addr 0 is written with 0x112233 and done=1.
- **Post-completion behaviour.**
  - Stimulus: after done, drive invalid=1 with arbitrary bytes for 20 cycles.
  - Required: inready=0, no imwe pulse, and done/cpuhold remain unchanged.
